// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader: state encoding, word type,
// the end-of-program marker and a byte-packing helper.
package instruction_loader_pkg;

    localparam int SIZE_DEFAULT = 32;

    typedef logic [31:0] word_t;

    localparam word_t HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_t;

    // Big-endian packing: earlier bytes move toward the MSB as new ones arrive.
    function automatic word_t shift_in_byte(input word_t word, input logic [7:0] data_byte);
        return {word[23:0], data_byte};
    endfunction

endpackage

// File: rtl/instruction_loader_if.sv
// Byte-stream input, instruction memory write port and load status of the
// instruction loader. The master side is the byte source / controller, the
// slave side is the loader itself.
interface instruction_loader_if #(
    parameter int ADDR_W = 4,
    parameter int SIZE   = 32
);
    logic              start;
    logic [7:0]        rx_byte;
    logic              byte_valid;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [SIZE-1:0]   imem_data;
    logic              stall;
    logic              done;
    logic              full;
    logic [ADDR_W:0]   count;

    modport master (
        output start, rx_byte, byte_valid,
        input  byte_ready, imem_we, imem_addr, imem_data, stall, done, full, count
    );

    modport slave (
        input  start, rx_byte, byte_valid,
        output byte_ready, imem_we, imem_addr, imem_data, stall, done, full, count
    );

endinterface

// File: rtl/instruction_loader.sv
// Instruction memory loader: packs a byte stream into 32-bit big-endian words
// and writes them to consecutive word addresses from 0, holding the pipeline
// stalled for the whole load. A load ends on the halt word (which is itself
// written) or when the last memory word has been written.
//
//   state | meaning
//   IDLE  | waiting for start; no stall, no bytes accepted
//   RECV  | accepting bytes, 4 per word, MSB first
//   WRITE | one-cycle write pulse of the assembled word
//   DONE  | one-cycle done pulse, stall still held
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int    SIZE            = SIZE_DEFAULT,
    parameter int    MAX_INSTRUCTION = 10,
    parameter int    ADDR_W          = 4,
    parameter word_t HALT_WORD       = HALT_WORD_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    instruction_loader_if.slave  bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_INSTRUCTION - 1);

    loader_state_t     state;
    logic [1:0]        byte_idx;
    word_t             word_sr;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   count;
    logic              byte_ready;
    logic              imem_we;
    logic              stall;
    logic              done;
    logic              full;
    logic              transfer;

    assign transfer = bus.byte_valid & byte_ready;

    // Loader FSM with all outputs registered; the shift register doubles as
    // the write-data register, so it is stable for the whole write pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            byte_idx   <= 2'd0;
            word_sr    <= '0;
            addr       <= '0;
            count      <= '0;
            byte_ready <= 1'b0;
            imem_we    <= 1'b0;
            stall      <= 1'b0;
            done       <= 1'b0;
            full       <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            done    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state      <= ST_RECV;
                        addr       <= '0;
                        count      <= '0;
                        byte_idx   <= 2'd0;
                        full       <= 1'b0;
                        stall      <= 1'b1;
                        byte_ready <= 1'b1;
                    end
                end
                ST_RECV: begin
                    if (transfer) begin
                        word_sr  <= shift_in_byte(word_sr, bus.rx_byte);
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            state      <= ST_WRITE;
                            byte_ready <= 1'b0;
                            imem_we    <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    // The word is committed to memory on this edge, so it is
                    // counted here whichever way the load continues.
                    count <= count + 1'b1;
                    if (word_sr == HALT_WORD) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else if (addr == LAST_ADDR) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        full  <= 1'b1;
                    end else begin
                        state      <= ST_RECV;
                        addr       <= addr + 1'b1;
                        byte_idx   <= 2'd0;
                        byte_ready <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    stall <= 1'b0;
                end
                default: begin
                    state      <= ST_IDLE;
                    stall      <= 1'b0;
                    byte_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.byte_ready = byte_ready;
    assign bus.imem_we    = imem_we;
    assign bus.imem_addr  = addr;
    assign bus.imem_data  = word_sr;
    assign bus.stall      = stall;
    assign bus.done       = done;
    assign bus.full       = full;
    assign bus.count      = count;

endmodule
